trigger_sync_hub: RTL and testbench

- Network-side counterpart of the per-actor trigger.
- Collects each trigger's sleep, sync_exec, sync_wait, waited and ap_idle flags and broadcasts the aggregated all_sleep, all_sync, all_sync_wait and per-actor all_waited back to the triggers.
- Owns the host ap_start/ap_done handshake for the whole actor network: starts all triggers together and reports completion once every trigger has returned to idle after the final synced WAIT round.

---
 rtl/trigger_sync_hub.sv | 124 ++++++++++++
 tb/tb_trigger_sync_hub.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sync_hub.sv
// Network-side trigger hub: aggregates per-actor trigger flags and owns the host ap_start/ap_done handshake.
// Optional RUN-state watchdog enabled by defining TRIGGER_SYNC_HUB_WATCHDOG_EN.
module trigger_sync_hub #(
    parameter int NUM_ACTORS      = 4,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  trigger_start,
    input  logic [NUM_ACTORS-1:0] actor_sleep,
    input  logic [NUM_ACTORS-1:0] actor_sync_exec,
    input  logic [NUM_ACTORS-1:0] actor_sync_wait,
    input  logic [NUM_ACTORS-1:0] actor_waited,
    input  logic [NUM_ACTORS-1:0] actor_idle,
    output logic                  all_sleep,
    output logic                  all_sync,
    output logic                  all_sync_wait,
    output logic [NUM_ACTORS-1:0] all_waited,
    output logic [31:0]           sync_rounds,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  seen_busy_q;
    logic                  sync_prev_q;
    logic [31:0]           sync_rounds_q;
    logic                  run;
    logic                  accept;
    logic                  wd_expire;
    logic [NUM_ACTORS-1:0] waited_raw;

    assign run    = (state_q == S_RUN);
    assign accept = (state_q == S_IDLE) && ap_start;

    // Bit i ignores its own waited flag; a single actor therefore sees a vacuous 1.
    for (genvar i = 0; i < NUM_ACTORS; i++) begin : g_waited
        logic [NUM_ACTORS-1:0] others;
        always_comb begin
            others    = actor_waited;
            others[i] = 1'b1;
        end
        assign waited_raw[i] = &others;
    end

    // Idle triggers still report sleep/sync_wait, so everything is masked outside RUN.
    assign all_sleep     = run && (&actor_sleep);
    assign all_sync      = run && (&(actor_sync_exec | actor_sync_wait));
    assign all_sync_wait = run && (&actor_sync_wait);
    assign all_waited    = run ? waited_raw : '0;

    assign ap_idle       = (state_q == S_IDLE);
    assign trigger_start = (state_q == S_START);
    assign ap_done       = (state_q == S_DONE);
    assign ap_ready      = ap_done;
    assign sync_rounds   = sync_rounds_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ap_start) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if ((seen_busy_q && (&actor_idle)) || wd_expire) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            seen_busy_q   <= 1'b0;
            sync_prev_q   <= 1'b0;
            sync_rounds_q <= '0;
        end else begin
            state_q     <= state_d;
            sync_prev_q <= all_sync;
            if (accept) begin
                seen_busy_q   <= 1'b0;
                sync_rounds_q <= '0;
            end else begin
                if (run && !(&actor_idle)) seen_busy_q <= 1'b1;
                if (all_sync && !sync_prev_q && (sync_rounds_q != 32'hFFFF_FFFF))
                    sync_rounds_q <= sync_rounds_q + 32'd1;
            end
        end
    end

`ifdef TRIGGER_SYNC_HUB_WATCHDOG_EN
    logic [31:0] wd_cnt_q;
    logic        timeout_q;

    // Fires on the RUN cycle in which the count reaches the limit; DONE follows.
    assign wd_expire = run && (({1'b0, wd_cnt_q} + 33'd1) >= 33'(WATCHDOG_CYCLES));
    assign timeout   = timeout_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) timeout_q <= 1'b0;
            else if (wd_expire) timeout_q <= 1'b1;
            if (state_q == S_START) wd_cnt_q <= '0;
            else if (run) wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_sync_hub.sv
// Self-checking bench for trigger_sync_hub: aggregation vector table, handshake timing,
// sync round counting, async reset and (when TRIGGER_SYNC_HUB_WATCHDOG_EN is defined) the watchdog.
module tb_trigger_sync_hub;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ap_start;
    logic         ap_done, ap_ready, ap_idle, trigger_start;
    logic [N-1:0] actor_sleep, actor_sync_exec, actor_sync_wait, actor_waited, actor_idle;
    logic         all_sleep, all_sync, all_sync_wait;
    logic [N-1:0] all_waited;
    logic [31:0]  sync_rounds;
    logic         timeout;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [N-1:0] sleep, sync_exec, sync_wait, waited;
        logic         e_sleep, e_sync, e_sync_wait;
        logic [N-1:0] e_waited;
    } vec_t;
    vec_t vecs[7];

    trigger_sync_hub #(.NUM_ACTORS(N), .WATCHDOG_CYCLES(100)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle), .trigger_start(trigger_start),
        .actor_sleep(actor_sleep), .actor_sync_exec(actor_sync_exec),
        .actor_sync_wait(actor_sync_wait), .actor_waited(actor_waited), .actor_idle(actor_idle),
        .all_sleep(all_sleep), .all_sync(all_sync), .all_sync_wait(all_sync_wait),
        .all_waited(all_waited), .sync_rounds(sync_rounds), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_flags(input logic [N-1:0] sl, input logic [N-1:0] ex,
                               input logic [N-1:0] sw, input logic [N-1:0] wt);
        actor_sleep = sl; actor_sync_exec = ex; actor_sync_wait = sw; actor_waited = wt;
    endtask

    // Pulse ap_start for one sampled edge; returns just after the edge that enters START.
    task automatic pulse_start();
        @(posedge clk); #1 ap_start = 1'b1;
        @(posedge clk); #1 ap_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic exp_to, output int cycles);
        logic [31:0] exp_r;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!ap_done && cycles < 300);
        check({name, "_done_seen"}, ap_done, 1'b1);
        if (ap_done) begin
            check({name, "_ready"}, ap_ready, 1'b1);
            check({name, "_timeout"}, timeout, exp_to);
            if (exp_q.size() == 0) check({name, "_queue_empty"}, 1, 0);
            else begin
                exp_r = exp_q.pop_front();
                check({name, "_rounds"}, sync_rounds, exp_r);
            end
        end
    endtask

    initial begin
        int cyc;
        int rounds_exp;
        logic prev;

        vecs[0] = '{4'b0000, 4'b0000, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{4'b0000, 4'b0000, 4'b1111, 4'b1110, 1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[2] = '{4'b1111, 4'b1000, 4'b0111, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b1111};
        vecs[3] = '{4'b0111, 4'b0000, 4'b0000, 4'b1101, 1'b0, 1'b0, 1'b0, 4'b0010};
        vecs[4] = '{4'b0000, 4'b1111, 4'b0000, 4'b0111, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[5] = '{4'b1011, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[6] = '{4'b0000, 4'b0011, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};

        // Reset with stale "idle-looking" flags that must not leak out.
        rst_n = 1'b0; ap_start = 1'b0; actor_idle = '1;
        drive_flags('1, '1, '1, '1);
        #2;
        check("rst_idle", ap_idle, 1'b1);
        check("rst_done", ap_done, 1'b0);
        check("rst_ready", ap_ready, 1'b0);
        check("rst_tstart", trigger_start, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_all", {all_sleep, all_sync, all_sync_wait, all_waited}, '0);
        check("rst_rounds", sync_rounds, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_gated", {all_sleep, all_sync, all_sync_wait, all_waited}, '0);

        // Run 1: handshake timing; busy from k=2 to k=39, idle again at k=40.
        drive_flags('1, '0, '0, '0);
        exp_q.push_back(32'd0);
        pulse_start();
        for (int k = 1; k <= 44; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            actor_idle = (k >= 2 && k < 40) ? '0 : '1;
            @(negedge clk);
            check($sformatf("r1_tstart_k%0d", k), trigger_start, k == 1);
            check($sformatf("r1_done_k%0d", k), ap_done, k == 41);
            check($sformatf("r1_idle_k%0d", k), ap_idle, k >= 42);
            check($sformatf("r1_sleep_k%0d", k), all_sleep, k >= 2 && k <= 40);
            if (ap_done) check("r1_rounds", sync_rounds, exp_q.pop_front());
        end

        // Run 2: aggregation table inside RUN, sync rounds counted from expected all_sync edges.
        drive_flags('0, '0, '0, '0);
        pulse_start();
        @(posedge clk); #1 actor_idle = '0;
        rounds_exp = 0; prev = 1'b0;
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive_flags(vecs[i].sleep, vecs[i].sync_exec, vecs[i].sync_wait, vecs[i].waited);
            if (vecs[i].e_sync && !prev) rounds_exp++;
            prev = vecs[i].e_sync;
            @(negedge clk);
            check($sformatf("v%0d_sleep", i), all_sleep, vecs[i].e_sleep);
            check($sformatf("v%0d_sync", i), all_sync, vecs[i].e_sync);
            check($sformatf("v%0d_sync_wait", i), all_sync_wait, vecs[i].e_sync_wait);
            check($sformatf("v%0d_waited", i), all_waited, vecs[i].e_waited);
        end
        // Final sync rise lands in the same cycle all triggers go idle.
        @(posedge clk); #1;
        drive_flags('0, '0, '1, '0);
        actor_idle = '1;
        if (!prev) rounds_exp++;
        exp_q.push_back(rounds_exp);
        @(negedge clk);
        check("r2_last_sync_wait", all_sync_wait, 1'b1);
        wait_done("r2", 1'b0, cyc);
        check("r2_done_latency", cyc, 1);
        repeat (2) begin
            @(negedge clk);
            check("r2_rounds_hold", sync_rounds, rounds_exp);
            check("r2_idle_gated", all_sync_wait, 1'b0);
        end

        // Run 3: ap_start held through DONE is taken on the following IDLE cycle.
        drive_flags('0, '0, '0, '0);
        @(posedge clk); #1 ap_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("r3_tstart", trigger_start, 1'b1);
        check("r3_rounds_clear", sync_rounds, 32'd0);
        @(posedge clk); #1 actor_idle = '0;
        @(posedge clk); #1 actor_idle = '0;
        @(posedge clk); #1 actor_idle = '1;
        exp_q.push_back(32'd0);
        wait_done("r3", 1'b0, cyc);
        @(negedge clk);
        check("r3_after_done_idle", ap_idle, 1'b1);
        check("r3_after_done_tstart", trigger_start, 1'b0);
        @(negedge clk);
        check("r3_restart_tstart", trigger_start, 1'b1);

        // Run 4: async reset in the middle of RUN.
        @(posedge clk); #1 ap_start = 1'b0; actor_idle = '0; actor_sync_exec = '1;
        @(posedge clk);
        @(negedge clk);
        check("r4_rounds_pre", sync_rounds, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("r4_rst_idle", ap_idle, 1'b1);
        check("r4_rst_rounds", sync_rounds, 32'd0);
        check("r4_rst_all", {all_sleep, all_sync, all_sync_wait, all_waited}, '0);
        check("r4_rst_hs", {ap_done, ap_ready, trigger_start}, 3'b000);
        @(posedge clk); #1 rst_n = 1'b1; actor_idle = '1; actor_sync_exec = '0;
        pulse_start();
        @(negedge clk);
        check("r4_restart_tstart", trigger_start, 1'b1);
        @(posedge clk); #1 actor_idle = '0;
        @(posedge clk); #1 actor_idle = '1;
        exp_q.push_back(32'd0);
        wait_done("r4", 1'b0, cyc);

`ifdef TRIGGER_SYNC_HUB_WATCHDOG_EN
        // Watchdog: triggers never finish; 100 RUN cycles then DONE with timeout.
        actor_idle = '0;
        pulse_start();
        @(negedge clk);
        check("wd_tstart", trigger_start, 1'b1);
        exp_q.push_back(32'd0);
        wait_done("wd", 1'b1, cyc);
        check("wd_cycles", cyc, 101);
        @(negedge clk);
        check("wd_sticky", timeout, 1'b1);
        pulse_start();
        @(negedge clk);
        check("wd_clear", timeout, 1'b0);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
`else
        @(negedge clk);
        check("no_wd_timeout", timeout, 1'b0);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end
endmodule
